// File: rtl/ppc_fetch_queue.sv
// ppc_fetch_queue
// ---------------
// Decoupled instruction-fetch unit. It reads aligned 64-bit words through one
// memory read port, splits each word into two 32-bit big-endian instructions
// and buffers them, together with their PCs, in a DEPTH-entry circular queue
// that feeds decode. A redirect (branch/exception) or reset flushes the queue
// and any fetch still in flight, and restarts fetch at the new PC.
//
// Bit numbering follows the PowerPC convention: bit 0 is the MSB.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   redirect     flush the queue and restart fetch at redirectPc
//   redirectPc   new fetch PC (two low bits ignored)
//   memReadEn    read request to the memory port
//   memReadAddr  word address of the request (fetch PC without its 3 low bits)
//   memReadData  read data, valid exactly one cycle after memReadEn
//   outValid     head entry holds an instruction
//   outInst      head instruction
//   outPc        PC of the head instruction
//   outReady     decode accepts the head this cycle
//   count        number of occupied queue entries

module ppc_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                PC_W     = 64,
    parameter logic [0:PC_W-1]   RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [0:PC_W-1]              redirectPc,
    output logic                         memReadEn,
    output logic [0:PC_W-4]              memReadAddr,
    input  logic [0:63]                  memReadData,
    output logic                         outValid,
    output logic [0:31]                  outInst,
    output logic [0:PC_W-1]              outPc,
    input  logic                         outReady,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = PC_W - 3;

    localparam logic [0:WA_W-1] WORD_ONE = WA_W'(1);
    localparam logic [0:PC_W-1] PC_FOUR  = PC_W'(4);

    // Queue storage: one instruction and its PC per entry.
    logic [0:31]       inst_mem [DEPTH];
    logic [0:PC_W-1]   pc_mem   [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // Fetch state: next fetch PC and the request issued last cycle.
    logic [0:PC_W-1]   fpc;
    logic              in_flight;
    logic              flight_half;
    logic [0:PC_W-1]   flight_pc;

    // Entries to be written this cycle (first goes to tail, second to tail+1).
    logic [1:0]        n_push;
    logic [0:31]       first_inst;
    logic [0:PC_W-1]   first_pc;
    logic [0:31]       second_inst;
    logic [0:PC_W-1]   second_pc;
    logic              pop;
    logic              flush;
    int                free_slots;

    // The two low PC bits of a redirect target are forced to zero.
    logic              unused_pc_bits;
    assign unused_pc_bits = &{1'b0, redirectPc[PC_W-2:PC_W-1]};

    assign flush       = reset | redirect;
    assign memReadAddr = fpc[0:PC_W-4];
    assign outValid    = (count != '0);
    assign outInst     = inst_mem[head];
    assign outPc       = pc_mem[head];

    // Issue only when the queue can absorb a full two-instruction response on
    // top of whatever is already stored or still returning. A dequeue in the
    // same cycle is deliberately not credited, keeping this path short.
    always_comb begin
        free_slots = DEPTH - int'(count) - (in_flight ? 2 : 0);
        memReadEn  = ~flush & (free_slots >= 2);
    end

    // Response decode: a request that started on the upper half of a word
    // (PC bit 61 set for PC_W=64) only carries the lower 32 data bits.
    always_comb begin
        n_push      = 2'd0;
        first_inst  = '0;
        first_pc    = '0;
        second_inst = '0;
        second_pc   = '0;
        if (in_flight && !flush) begin
            if (!flight_half) begin
                first_inst  = memReadData[0:31];
                first_pc    = flight_pc;
                second_inst = memReadData[32:63];
                second_pc   = flight_pc + PC_FOUR;
                n_push      = 2'd2;
            end else begin
                first_inst  = memReadData[32:63];
                first_pc    = flight_pc;
                n_push      = 2'd1;
            end
        end
        pop = outValid & outReady & ~flush;
    end

    // Queue storage writes; flushed entries are simply forgotten via count.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            inst_mem[tail] <= first_inst;
            pc_mem[tail]   <= first_pc;
        end
        if (n_push == 2'd2) begin
            inst_mem[tail + PTR_W'(1)] <= second_inst;
            pc_mem[tail + PTR_W'(1)]   <= second_pc;
        end
    end

    // Pointers, occupancy and fetch state. Reset is treated exactly like a
    // redirect to RESET_PC, so both share the flush path.
    always_ff @(posedge clk) begin
        if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            in_flight <= 1'b0;
            if (reset) begin
                fpc <= RESET_PC;
            end else begin
                fpc <= {redirectPc[0:PC_W-3], 2'b00};
            end
        end else begin
            tail      <= tail + PTR_W'(n_push);
            head      <= head + PTR_W'(pop);
            count     <= count + CNT_W'(n_push) - CNT_W'(pop);
            in_flight <= memReadEn;
            if (memReadEn) begin
                flight_pc   <= fpc;
                flight_half <= fpc[PC_W-3];
                fpc         <= {fpc[0:PC_W-4] + WORD_ONE, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// tb_ppc_fetch_queue
// ------------------
// Self-checking bench for ppc_fetch_queue (DEPTH=4, PC_W=64, RESET_PC=0).
// A behavioural memory answers read requests one cycle later. The reference
// model tracks the program-order instruction stream: after a reset or
// redirect, decode must see consecutive PCs starting at the aligned target,
// each carrying the matching half of the memory word. It also tracks the next
// expected fetch address and the request-credit rule.

module tb_ppc_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic           clk;
    logic           reset;
    logic           redirect;
    logic [0:63]    redirectPc;
    logic           memReadEn;
    logic [0:60]    memReadAddr;
    logic [0:63]    memReadData;
    logic           outValid;
    logic [0:31]    outInst;
    logic [0:63]    outPc;
    logic           outReady;
    logic [2:0]     count;

    int passed;
    int failed;
    int total;

    // Reference model state.
    logic [63:0]    exp_pc;
    logic [63:0]    exp_fpc;
    logic           infl;
    logic           stall;
    logic [63:0]    stall_pc;
    logic [31:0]    stall_inst;

    ppc_fetch_queue #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .memReadEn   (memReadEn),
        .memReadAddr (memReadAddr),
        .memReadData (memReadData),
        .outValid    (outValid),
        .outInst     (outInst),
        .outPc       (outPc),
        .outReady    (outReady),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: three fixed words used by the directed steps, a
    // address-derived pattern everywhere else.
    function automatic logic [63:0] mem_word(input logic [63:0] addr);
        case (addr)
            64'd0:   return 64'h3860_0001_3880_0002;
            64'd1:   return 64'h4400_0002_6000_0000;
            64'd2:   return 64'hAAAA_AAAA_BBBB_BBBB;
            default: return {addr[31:0] ^ 32'h1357_9BDF, ~addr[31:0] ^ 32'h2468_ACE0};
        endcase
    endfunction

    function automatic logic [31:0] inst_at(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word(pc >> 3);
        return pc[2] ? w[31:0] : w[63:32];
    endfunction

    // One-cycle read latency memory model.
    always @(posedge clk) begin
        if (memReadEn) begin
            memReadData <= mem_word(64'(memReadAddr));
        end else begin
            memReadData <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle checks against the reference model, sampled at the negedge.
    task automatic monitor();
        int  free_slots;
        logic exp_en;
        if (reset) begin
            chk("en_in_reset", 64'(memReadEn), 64'd0);
            exp_pc  = RESET_PC;
            exp_fpc = RESET_PC;
            infl    = 1'b0;
            stall   = 1'b0;
        end else begin
            chk("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
            chk("valid_vs_count", 64'(outValid), 64'(count != 3'd0));
            free_slots = DEPTH - int'(count) - (infl ? 2 : 0);
            exp_en     = !redirect && (free_slots >= 2);
            chk("issue_rule", 64'(memReadEn), 64'(exp_en));
            if (memReadEn) begin
                chk("fetch_addr", 64'(memReadAddr), exp_fpc >> 3);
            end
            if (stall) begin
                chk("stall_valid", 64'(outValid), 64'd1);
                chk("stall_pc", 64'(outPc), stall_pc);
                chk("stall_inst", 64'(outInst), 64'(stall_inst));
            end
            if (redirect) begin
                exp_pc  = {redirectPc[0:61], 2'b00};
                exp_fpc = exp_pc;
                infl    = 1'b0;
                stall   = 1'b0;
            end else begin
                if (outValid && outReady) begin
                    chk("stream_pc", 64'(outPc), exp_pc);
                    chk("stream_inst", 64'(outInst), 64'(inst_at(exp_pc)));
                    exp_pc = exp_pc + 64'd4;
                end
                stall      = outValid && !outReady;
                stall_pc   = 64'(outPc);
                stall_inst = outInst;
                infl       = memReadEn;
                if (memReadEn) begin
                    exp_fpc = ((exp_fpc >> 3) + 64'd1) << 3;
                end
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            neg();
            adv();
        end
    endtask

    task automatic doRedirect(input logic [63:0] pc);
        redirect   = 1'b1;
        redirectPc = pc;
        neg();
        chk("en_in_redirect", 64'(memReadEn), 64'd0);
        adv();
        redirect = 1'b0;
    endtask

    initial begin
        passed     = 0;
        failed     = 0;
        total      = 0;
        stall      = 1'b0;
        infl       = 1'b0;
        exp_pc     = RESET_PC;
        exp_fpc    = RESET_PC;
        reset      = 1'b1;
        redirect   = 1'b0;
        redirectPc = '0;
        outReady   = 1'b0;

        // Reset state.
        adv();
        neg();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(outValid), 64'd0);
        adv();
        reset    = 1'b0;
        outReady = 1'b1;

        // Straight-line start from RESET_PC.
        neg();
        chk("start_en0", 64'(memReadEn), 64'd1);
        chk("start_addr0", 64'(memReadAddr), 64'd0);
        adv();
        neg();
        chk("start_en1", 64'(memReadEn), 64'd1);
        chk("start_addr1", 64'(memReadAddr), 64'd1);
        adv();
        neg();
        chk("start_pc0", 64'(outPc), 64'h0);
        chk("start_inst0", 64'(outInst), 64'h3860_0001);
        chk("start_count2", 64'(count), 64'd2);
        adv();
        neg();
        chk("start_pc4", 64'(outPc), 64'h4);
        chk("start_inst4", 64'(outInst), 64'h3880_0002);
        chk("start_count3", 64'(count), 64'd3);
        adv();
        neg();
        chk("start_pc8", 64'(outPc), 64'h8);
        chk("start_inst8", 64'(outInst), 64'h4400_0002);
        chk("start_addr2", 64'(memReadAddr), 64'd2);
        adv();
        neg();
        chk("start_pc12", 64'(outPc), 64'hC);
        chk("start_inst12", 64'(outInst), 64'h6000_0000);
        chk("pushpop_pre", 64'(count), 64'd1);
        adv();
        neg();
        chk("pushpop_count", 64'(count), 64'd2);
        chk("pushpop_pc", 64'(outPc), 64'h10);
        adv();
        applyStimulus(14);

        // Odd start: only the lower half of word 2 is enqueued.
        outReady = 1'b0;
        doRedirect(64'h14);
        neg();
        chk("odd_count0", 64'(count), 64'd0);
        chk("odd_addr2", 64'(memReadAddr), 64'd2);
        adv();
        neg();
        chk("odd_addr3", 64'(memReadAddr), 64'd3);
        adv();
        neg();
        chk("odd_pc", 64'(outPc), 64'h14);
        chk("odd_inst", 64'(outInst), 64'hBBBB_BBBB);
        chk("odd_count1", 64'(count), 64'd1);
        adv();
        neg();
        chk("odd_count3", 64'(count), 64'd3);
        adv();
        outReady = 1'b1;
        applyStimulus(3);

        // Backpressure: queue fills, issue resumes only at two free slots.
        outReady = 1'b0;
        doRedirect(64'h0);
        applyStimulus(2);
        neg();
        chk("bp_count2", 64'(count), 64'd2);
        adv();
        neg();
        chk("bp_count4", 64'(count), 64'd4);
        chk("bp_en_full", 64'(memReadEn), 64'd0);
        adv();
        outReady = 1'b1;
        neg();
        adv();
        outReady = 1'b0;
        neg();
        chk("bp_count3", 64'(count), 64'd3);
        chk("bp_en_3", 64'(memReadEn), 64'd0);
        adv();
        outReady = 1'b1;
        neg();
        chk("bp_en_nocredit", 64'(memReadEn), 64'd0);
        adv();
        outReady = 1'b0;
        neg();
        chk("bp_count2b", 64'(count), 64'd2);
        chk("bp_en_resume", 64'(memReadEn), 64'd1);
        adv();

        // Redirect while a fetch is in flight: the response is dropped.
        doRedirect(64'h28);
        neg();
        chk("flight_addr5", 64'(memReadAddr), 64'd5);
        adv();
        doRedirect(64'h100);
        outReady = 1'b1;
        neg();
        chk("flight_count0", 64'(count), 64'd0);
        chk("flight_valid0", 64'(outValid), 64'd0);
        chk("flight_addr20", 64'(memReadAddr), 64'h20);
        adv();
        neg();
        adv();
        neg();
        chk("flight_first_pc", 64'(outPc), 64'h100);
        adv();

        // Unaligned redirect target is truncated to a 4-byte boundary.
        outReady = 1'b0;
        doRedirect(64'h107);
        neg();
        chk("unal_addr", 64'(memReadAddr), 64'h20);
        adv();
        applyStimulus(1);
        neg();
        chk("unal_pc", 64'(outPc), 64'h104);
        chk("unal_inst", 64'(outInst), 64'(inst_at(64'h104)));
        chk("unal_count", 64'(count), 64'd1);
        adv();

        // Fetch across the top of the address space.
        outReady = 1'b1;
        doRedirect(64'hFFFF_FFFF_FFFF_FFF4);
        applyStimulus(12);

        // Randomized traffic: backpressure, redirects and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            outReady = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       redirectPc = {$urandom, $urandom};
                1:       redirectPc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
                default: redirectPc = 64'($urandom_range(0, 4095));
            endcase
            neg();
            adv();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        outReady = 1'b1;
        applyStimulus(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
